cmp_share_arb: RTL

- Time-shares one combinational signed less-than-or-equal comparator among N_REQ requesters.
- Round-robin arbitration; the granted requester's operand pair is registered, compared, and the result returned on a per-requester response handshake.
- Sits between crypto datapath clients (range checks, bound tests) and the single comparator instance.

---
 rtl/cmp_share_pkg.sv | 39 +++
 rtl/signed_lteq_cmp.sv | 17 +
 rtl/cmp_share_arb.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cmp_share_pkg.sv
// Shared types and helpers for the time-shared signed comparator arbiter.
package cmp_share_pkg;

  localparam int N_REQ_MAX = 16;
  localparam int PTR_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic             found;
    logic [PTR_W-1:0] idx;
  } pick_t;

  // Round-robin pick: first asserted valid bit searching ptr, ptr+1, ... modulo n.
  function automatic pick_t rr_pick(input logic [N_REQ_MAX-1:0] valid,
                                    input logic [PTR_W-1:0]     ptr,
                                    input int                   n);
    pick_t res;
    int    j;
    res.found = 1'b0;
    res.idx   = '0;
    for (int i = 0; i < N_REQ_MAX; i++) begin
      if (i < n) begin
        j = int'(ptr) + i;
        if (j >= n) j = j - n;
        if (!res.found && valid[j[PTR_W-1:0]]) begin
          res.found = 1'b1;
          res.idx   = j[PTR_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/signed_lteq_cmp.sv
// Combinational two's-complement less-than-or-equal and equality comparator.
module signed_lteq_cmp #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lteq,
  output logic             eq
);

  // Both results come straight from the operands; the sign bit is honoured.
  always_comb begin
    lteq = ($signed(a) <= $signed(b));
    eq   = (a == b);
  end

endmodule

// File: rtl/cmp_share_arb.sv
// Round-robin arbiter time-sharing one signed comparator among N_REQ clients.
module cmp_share_arb
  import cmp_share_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic                   rsp_lteq,
  output logic                   rsp_eq,
  output logic [IDW-1:0]         rsp_tag,
  output logic                   busy
);

  state_e             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [IDW-1:0]     tag_q, tag_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic               rsp_lteq_q, rsp_lteq_d;
  logic               rsp_eq_q, rsp_eq_d;
  logic [IDW-1:0]     rsp_tag_q, rsp_tag_d;
  logic [N_REQ-1:0]   ready_int;

  logic [N_REQ_MAX-1:0] valid_ext;
  pick_t                pick;
  logic [IDW-1:0]       grant;
  logic                 cmp_lteq;
  logic                 cmp_eq;

  signed_lteq_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a    (a_q),
    .b    (b_q),
    .lteq (cmp_lteq),
    .eq   (cmp_eq)
  );

  // Widen the request vector and run the round-robin search from rr_ptr.
  always_comb begin
    valid_ext              = '0;
    valid_ext[N_REQ-1:0]   = req_valid;
    pick                   = rr_pick(valid_ext, PTR_W'(rr_ptr_q), N_REQ);
    grant                  = pick.idx[IDW-1:0];
  end

  // Next-state logic: grant in IDLE or on a RESP handshake, capture result in CMP.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    tag_d       = tag_q;
    rsp_valid_d = rsp_valid_q;
    rsp_lteq_d  = rsp_lteq_q;
    rsp_eq_d    = rsp_eq_q;
    rsp_tag_d   = rsp_tag_q;
    ready_int   = '0;

    unique case (state_q)
      IDLE: begin
        if (pick.found) begin
          ready_int[grant] = 1'b1;
        end
      end
      CMP: begin
        state_d            = RESP;
        rsp_valid_d        = '0;
        rsp_valid_d[tag_q] = 1'b1;
        rsp_lteq_d         = cmp_lteq;
        rsp_eq_d           = cmp_eq;
        rsp_tag_d          = tag_q;
      end
      RESP: begin
        if (rsp_ready[rsp_tag_q]) begin
          rsp_valid_d = '0;
          if (pick.found) begin
            ready_int[grant] = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (|ready_int) begin
      a_d      = req_a[int'(grant)*WIDTH +: WIDTH];
      b_d      = req_b[int'(grant)*WIDTH +: WIDTH];
      tag_d    = grant;
      rr_ptr_d = (grant == IDW'(N_REQ-1)) ? '0 : grant + IDW'(1);
      state_d  = CMP;
    end
  end

  // State, operand and response registers; reset discards any in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      rsp_valid_q <= '0;
      rsp_lteq_q  <= 1'b0;
      rsp_eq_q    <= 1'b0;
      rsp_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_lteq_q  <= rsp_lteq_d;
      rsp_eq_q    <= rsp_eq_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

  // Ready is masked by reset so nothing is offered while reset is held.
  always_comb begin
    req_ready = rst_n ? ready_int : '0;
    rsp_valid = rsp_valid_q;
    rsp_lteq  = rsp_lteq_q;
    rsp_eq    = rsp_eq_q;
    rsp_tag   = rsp_tag_q;
    busy      = (state_q != IDLE);
  end

endmodule
